alarm_intr_ctrl: RTL and testbench

//  Multi-channel sticky-alarm and interrupt block: NCH channels of WIDTH alarm bits.

---
 rtl/alarm_intr_pkg.sv | 9 +
 rtl/alarm_intr_chan.sv | 60 ++++++
 rtl/alarm_intr_ctrl.sv | 79 +++++++
 tb/tb_alarm_intr_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_intr_pkg.sv
// Shared register-select encodings for the sticky-alarm / interrupt block.
package alarm_intr_pkg;

  localparam logic [1:0] SEL_STICKY = 2'd0;
  localparam logic [1:0] SEL_MASK   = 2'd1;
  localparam logic [1:0] SEL_RAW    = 2'd2;
  localparam logic [1:0] SEL_RSV    = 2'd3;

endpackage

// File: rtl/alarm_intr_chan.sv
// One alarm channel: input delay, sticky capture, interrupt mask and irq flop.
// irq_nxt is the value irq_ch takes on the next edge, exported for the global irq.
module alarm_intr_chan #(
  parameter int WIDTH = 8,
  parameter int EDGE  = 0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             upactive,
  input  logic [WIDTH-1:0] alarm,
  input  logic             we,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] sticky,
  output logic [WIDTH-1:0] mask,
  output logic             irq_nxt,
  output logic             irq_ch
);
  import alarm_intr_pkg::*;

  logic [WIDTH-1:0] alarm_d1;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] sticky_nxt;
  logic             sticky_we;
  logic             mask_we;

  assign sticky_we = we && (sel == SEL_STICKY);
  assign mask_we   = we && (sel == SEL_MASK);
  assign irq_nxt   = |(sticky & mask);

  always_comb begin
    evt = (EDGE != 0) ? (alarm & ~alarm_d1) : alarm;
  end

  // In diag mode capture is frozen and a sticky write presets the register.
  always_comb begin
    sticky_nxt = sticky;
    if (upactive) begin
      if (sticky_we) sticky_nxt = evt | (sticky & ~wdata);
      else           sticky_nxt = evt | sticky;
    end else if (sticky_we) begin
      sticky_nxt = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      alarm_d1 <= '0;
      sticky   <= '0;
      mask     <= '0;
      irq_ch   <= 1'b0;
    end else begin
      alarm_d1 <= alarm;
      sticky   <= sticky_nxt;
      if (mask_we) mask <= wdata;
      irq_ch   <= irq_nxt;
    end
  end

endmodule

// File: rtl/alarm_intr_ctrl.sv
// Multi-channel sticky alarm and interrupt controller with processor register access.
// Address decode, combinational read mux and registered global interrupt live here.
module alarm_intr_ctrl #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int CHW   = 2,
  parameter int EDGE  = 0
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 upactive,
  input  logic [NCH*WIDTH-1:0] alarm,
  input  logic                 upen,
  input  logic                 upws,
  input  logic [CHW+1:0]       upa,
  input  logic [WIDTH-1:0]     updi,
  output logic [WIDTH-1:0]     updo,
  output logic [NCH*WIDTH-1:0] lalarm,
  output logic [NCH-1:0]       irq_ch,
  output logic                 irq
);
  import alarm_intr_pkg::*;

  logic [CHW-1:0]   chan;
  logic [1:0]       sel;
  logic             we;
  logic [WIDTH-1:0] sticky_a [NCH];
  logic [WIDTH-1:0] mask_a   [NCH];
  logic [NCH-1:0]   irq_nxt;

  assign chan = upa[CHW+1:2];
  assign sel  = upa[1:0];
  assign we   = upen & upws;

  // Only instantiated channels decode, so out-of-range writes fall on nothing.
  for (genvar c = 0; c < NCH; c++) begin : g_chan
    alarm_intr_chan #(
      .WIDTH (WIDTH),
      .EDGE  (EDGE)
    ) u_chan (
      .clk      (clk),
      .rst_     (rst_),
      .upactive (upactive),
      .alarm    (alarm[c*WIDTH +: WIDTH]),
      .we       (we && (chan == CHW'(c))),
      .sel      (sel),
      .wdata    (updi),
      .sticky   (sticky_a[c]),
      .mask     (mask_a[c]),
      .irq_nxt  (irq_nxt[c]),
      .irq_ch   (irq_ch[c])
    );
    assign lalarm[c*WIDTH +: WIDTH] = sticky_a[c];
  end

  always_comb begin
    updo = '0;
    if (upen) begin
      for (int c = 0; c < NCH; c++) begin
        if (chan == CHW'(c)) begin
          case (sel)
            SEL_STICKY: updo = sticky_a[c];
            SEL_MASK:   updo = mask_a[c];
            SEL_RAW:    updo = alarm[c*WIDTH +: WIDTH];
            SEL_RSV:    updo = '0;
            default:    updo = '0;
          endcase
        end
      end
    end
  end

  // Global irq uses the channels' next-state values so it rises with irq_ch.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) irq <= 1'b0;
    else       irq <= |irq_nxt;
  end

endmodule

// File: tb/tb_alarm_intr_ctrl.sv
// Directed scoreboard bench: a 4-channel level-capture instance and a 3-channel edge-capture instance.
module tb_alarm_intr_ctrl;
  import alarm_intr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_;
  logic        upactive;
  logic        upen;
  logic        upws;
  logic [3:0]  upa;
  logic [7:0]  updi;
  logic [31:0] alarm_a;
  logic [23:0] alarm_b;
  logic [7:0]  updo_a, updo_b;
  logic [31:0] lalarm_a;
  logic [23:0] lalarm_b;
  logic [3:0]  irq_ch_a;
  logic [2:0]  irq_ch_b;
  logic        irq_a, irq_b;

  always #5 clk = ~clk;

  alarm_intr_ctrl #(.WIDTH(8), .NCH(4), .CHW(2), .EDGE(0)) dut_a (
    .clk(clk), .rst_(rst_), .upactive(upactive), .alarm(alarm_a),
    .upen(upen), .upws(upws), .upa(upa), .updi(updi), .updo(updo_a),
    .lalarm(lalarm_a), .irq_ch(irq_ch_a), .irq(irq_a)
  );

  alarm_intr_ctrl #(.WIDTH(8), .NCH(3), .CHW(2), .EDGE(1)) dut_b (
    .clk(clk), .rst_(rst_), .upactive(upactive), .alarm(alarm_b),
    .upen(upen), .upws(upws), .upa(upa), .updi(updi), .updo(updo_b),
    .lalarm(lalarm_b), .irq_ch(irq_ch_b), .irq(irq_b)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic expect_v(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    upen = 1'b1; upws = 1'b1; upa = a; updi = d;
    step();
    upen = 1'b0; upws = 1'b0; updi = '0;
  endtask

  task automatic rd(input logic [3:0] a, input string tag, input logic [7:0] ev, input bit on_b);
    expect_v(tag, {24'h0, ev});
    upen = 1'b1; upws = 1'b0; upa = a;
    #1;
    observe(on_b ? {24'h0, updo_b} : {24'h0, updo_a});
    upen = 1'b0;
  endtask

  initial begin
    rst_ = 1'b0; upactive = 1'b1; upen = 1'b0; upws = 1'b0;
    upa = '0; updi = '0; alarm_a = '0; alarm_b = '0;

    // Reset state
    #2;
    expect_v("rst_irq_a", 0);       observe(irq_a);
    expect_v("rst_irq_ch_a", 0);    observe(irq_ch_a);
    expect_v("rst_lalarm_a", 0);    observe(lalarm_a);
    expect_v("rst_lalarm_b", 0);    observe(lalarm_b);
    expect_v("rst_irq_ch_b", 0);    observe(irq_ch_b);
    expect_v("rst_updo_a", 0);      observe(updo_a);
    step(); step();
    rst_ = 1'b1;
    step();

    // 1: level capture, one-cycle pulse on ch1 bit0, mask ch1 = 0x01
    wr({2'd1, SEL_MASK}, 8'h01);
    expect_v("t1_irq_ch_edge1", 0);
    expect_v("t1_irq_ch_edge2", 4'b0010);
    expect_v("t1_irq_edge2", 1);
    alarm_a[8] = 1'b1;
    step();
    alarm_a[8] = 1'b0;
    observe(irq_ch_a);
    step();
    observe(irq_ch_a);
    observe(irq_a);
    rd({2'd1, SEL_STICKY}, "t1_sticky", 8'h01, 0);
    step(); step();
    rd({2'd1, SEL_STICKY}, "t1_sticky_held", 8'h01, 0);
    expect_v("t1_lalarm", 32'h0000_0100); observe(lalarm_a);

    // 2: W1C clears, irq drops two edges after the write
    expect_v("t2_irq_edge1", 1);
    expect_v("t2_irq_edge2", 0);
    wr({2'd1, SEL_STICKY}, 8'h01);
    observe(irq_a);
    step();
    observe(irq_a);
    rd({2'd1, SEL_STICKY}, "t2_sticky_clr", 8'h00, 0);
    alarm_a[8] = 1'b1;
    step();
    wr({2'd1, SEL_STICKY}, 8'h01);
    rd({2'd1, SEL_STICKY}, "t2_set_wins", 8'h01, 0);
    step();
    expect_v("t2_irq_kept", 1); observe(irq_a);
    alarm_a[8] = 1'b0;
    wr({2'd1, SEL_STICKY}, 8'h01);
    step(); step();
    expect_v("t2_irq_final", 0); observe(irq_a);

    // 3: edge capture on instance b, ch0 bit7
    alarm_b[7:0] = 8'h80;
    step();
    rd({2'd0, SEL_STICKY}, "t3_first_cycle", 8'h80, 1);
    wr({2'd0, SEL_STICKY}, 8'h80);
    rd({2'd0, SEL_STICKY}, "t3_cleared", 8'h00, 1);
    step(); step();
    rd({2'd0, SEL_STICKY}, "t3_held_no_reset", 8'h00, 1);
    alarm_b[7:0] = 8'h00;
    step();
    alarm_b[7:0] = 8'h80;
    step();
    rd({2'd0, SEL_STICKY}, "t3_rerise", 8'h80, 1);
    wr({2'd0, SEL_STICKY}, 8'h80);
    alarm_b = '0;

    // 4: diag mode freezes capture; sticky write presets
    upactive = 1'b0;
    alarm_a = '1; alarm_b = '1;
    step(); step();
    rd({2'd0, SEL_STICKY}, "t4_ch0_frozen", 8'h00, 0);
    rd({2'd1, SEL_STICKY}, "t4_ch1_frozen", 8'h00, 0);
    rd({2'd3, SEL_STICKY}, "t4_ch3_frozen", 8'h00, 0);
    wr({2'd2, SEL_STICKY}, 8'h5A);
    rd({2'd2, SEL_STICKY}, "t4_ch2_preset", 8'h5A, 0);
    expect_v("t4_lalarm_ch2", 8'h5A); observe(lalarm_a[23:16]);
    expect_v("t4_irq_masked", 0);     observe(irq_a);
    alarm_a = '0; alarm_b = '0;
    wr({2'd2, SEL_STICKY}, 8'h00);
    upactive = 1'b1;

    // 5: mask gating on ch3
    alarm_a[28] = 1'b1;
    step();
    alarm_a[28] = 1'b0;
    step(); step();
    rd({2'd3, SEL_STICKY}, "t5_sticky", 8'h10, 0);
    expect_v("t5_irq_unmasked_off", 0); observe(irq_a);
    expect_v("t5_irq_edge1", 0);
    expect_v("t5_irq_edge2", 1);
    wr({2'd3, SEL_MASK}, 8'h10);
    observe(irq_a);
    step();
    observe(irq_a);
    alarm_a[31:24] = 8'hA5;
    rd({2'd3, SEL_RAW}, "t5_raw_live", 8'hA5, 0);
    alarm_a[31:24] = 8'h00;
    expect_v("t5_upen_low", 0);
    upen = 1'b0; upa = {2'd3, SEL_STICKY};
    #1;
    observe(updo_a);
    wr({2'd3, SEL_RAW}, 8'h00);
    rd({2'd3, SEL_MASK}, "t5_mask_after_raw_wr", 8'h10, 0);
    expect_v("t5_maskoff_edge1", 1);
    expect_v("t5_maskoff_edge2", 0);
    wr({2'd3, SEL_MASK}, 8'h00);
    observe(irq_a);
    step();
    observe(irq_a);
    rd({2'd3, SEL_STICKY}, "t5_sticky_kept", 8'h10, 0);

    // 6: async reset mid-run, then out-of-range and reserved accesses
    wr({2'd3, SEL_MASK}, 8'h10);
    step();
    expect_v("t6_irq_before_rst", 1); observe(irq_a);
    #2;
    rst_ = 1'b0;
    #1;
    expect_v("t6_rst_irq", 0);      observe(irq_a);
    expect_v("t6_rst_irq_ch", 0);   observe(irq_ch_a);
    expect_v("t6_rst_lalarm", 0);   observe(lalarm_a);
    step();
    rst_ = 1'b1;
    step();
    upactive = 1'b0;
    wr({2'd3, SEL_STICKY}, 8'hFF);
    wr({2'd3, SEL_MASK}, 8'hFF);
    upactive = 1'b1;
    step();
    expect_v("t6_oor_lalarm_b", 0); observe(lalarm_b);
    rd({2'd3, SEL_STICKY}, "t6_oor_rd_sticky", 8'h00, 1);
    rd({2'd3, SEL_MASK}, "t6_oor_rd_mask", 8'h00, 1);
    rd({2'd0, SEL_MASK}, "t6_b_ch0_mask", 8'h00, 1);
    expect_v("t6_irq_b", 0); observe(irq_b);
    wr({2'd1, SEL_MASK}, 8'h33);
    rd({2'd1, SEL_MASK}, "t6_mask_rw", 8'h33, 0);
    rd({2'd1, SEL_RSV}, "t6_reserved_rd", 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
